// File: rtl/uart_apb_regfile.sv
// UART register bank: APB-facing registers, TX/RX byte FIFOs and the
// interrupt flop that sit between the APB bridge and the UART tx/rx cores.
//
// Handshakes:
//   tx_valid/tx_ready: a byte leaves the TX FIFO on every clock edge where both
//   are high; tx_data is stable while tx_valid is high and tx_ready is low.
//   rx_valid: one-cycle push strobe with no backpressure; a byte that finds the
//   RX FIFO full (and no pop in the same cycle) is dropped and flags rx_ovr.
module uart_apb_regfile #(
    parameter int          ADDR_WD  = 12,
    parameter int          TX_DEPTH = 8,
    parameter int          RX_DEPTH = 8,
    parameter logic [15:0] BAUD_RST = 16'd868
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [ADDR_WD-1:0] apb_addr,
    input  logic               apb_read_en,
    input  logic               apb_write_en,
    input  logic [31:0]        apb_wdata,
    output logic [31:0]        apb_rdata,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               tx_en,
    output logic               rx_en,
    output logic [15:0]        baud_div,
    output logic               irq
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;
    localparam int WW    = ADDR_WD - 2;

    // Word offsets (byte address >> 2)
    localparam logic [WW-1:0] W_DATA     = WW'(0);
    localparam logic [WW-1:0] W_STATUS   = WW'(1);
    localparam logic [WW-1:0] W_CTRL     = WW'(2);
    localparam logic [WW-1:0] W_BAUD     = WW'(3);
    localparam logic [WW-1:0] W_INT_EN   = WW'(4);
    localparam logic [WW-1:0] W_INT_STAT = WW'(5);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        ctrl_q,     ctrl_d;
    logic [15:0]       baud_q,     baud_d;
    logic [3:0]        int_en_q,   int_en_d;
    logic              rx_ovr_q,   rx_ovr_d;
    logic              tx_ovf_q,   tx_ovf_d;
    logic              irq_q,      irq_d;
    logic              rd_phase_q, rd_phase_d;

    logic [7:0]        tx_mem_q [TX_DEPTH];
    logic [TX_PW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_PW-1:0]  tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0]  tx_count_q,  tx_count_d;

    logic [7:0]        rx_mem_q [RX_DEPTH];
    logic [RX_PW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_PW-1:0]  rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0]  rx_count_q,  rx_count_d;

    // ------------------------------------------------------------------
    // Decode and FIFO status
    // ------------------------------------------------------------------
    logic [WW-1:0] word;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push_req, tx_push_ok, tx_pop;
    logic          rx_push_req, rx_push_ok, rx_pop;
    logic          w1c_wr;
    logic [3:0]    int_stat;
    logic [7:0]    rx_head;
    logic [31:0]   status_w;
    logic          unused_bits;

    assign word        = apb_addr[ADDR_WD-1:2];
    assign unused_bits = &{1'b0, apb_addr[1:0], apb_wdata[31:16]};

    assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count_q == '0);

    assign tx_en    = ctrl_q[0];
    assign rx_en    = ctrl_q[1];
    assign baud_div = baud_q;
    assign irq      = irq_q;

    assign tx_valid = ~tx_empty & ctrl_q[0];
    assign tx_data  = tx_mem_q[tx_rd_ptr_q];

    // A full TX FIFO rejects the push even if a pop happens in the same cycle.
    assign tx_push_req = apb_write_en & (word == W_DATA);
    assign tx_push_ok  = tx_push_req & ~tx_full;
    assign tx_pop      = tx_valid & tx_ready;

    // RX pop happens on the edge that ends the access phase of a DATA read.
    assign rx_pop      = apb_read_en & rd_phase_q & (word == W_DATA) & ~rx_empty;
    assign rx_push_req = rx_valid & ctrl_q[1];
    assign rx_push_ok  = rx_push_req & (~rx_full | rx_pop);

    assign w1c_wr   = apb_write_en & (word == W_INT_STAT);
    assign int_stat = {tx_ovf_q, rx_ovr_q, tx_empty, ~rx_empty};

    assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
    assign status_w = {12'b0, 4'(rx_count_q), 4'b0, 4'(tx_count_q),
                       4'b0, rx_empty, rx_full, tx_empty, tx_full};

    // Read mux: combinational from the address, unmapped offsets read 0
    always_comb begin
        apb_rdata = 32'h0;
        case (word)
            W_DATA:     apb_rdata = {24'b0, rx_head};
            W_STATUS:   apb_rdata = status_w;
            W_CTRL:     apb_rdata = {30'b0, ctrl_q};
            W_BAUD:     apb_rdata = {16'b0, baud_q};
            W_INT_EN:   apb_rdata = {28'b0, int_en_q};
            W_INT_STAT: apb_rdata = {28'b0, int_stat};
            default:    apb_rdata = 32'h0;
        endcase
    end

    // Control/config register next state and sticky interrupt flags
    always_comb begin
        ctrl_d   = ctrl_q;
        baud_d   = baud_q;
        int_en_d = int_en_q;
        if (apb_write_en) begin
            if (word == W_CTRL)   ctrl_d   = apb_wdata[1:0];
            if (word == W_BAUD)   baud_d   = apb_wdata[15:0];
            if (word == W_INT_EN) int_en_d = apb_wdata[3:0];
        end
        // Clear first, then set, so a new event in the clearing cycle survives.
        rx_ovr_d = (rx_ovr_q & ~(w1c_wr & apb_wdata[2]))
                 | (rx_push_req & rx_full & ~rx_pop);
        tx_ovf_d = (tx_ovf_q & ~(w1c_wr & apb_wdata[3]))
                 | (tx_push_req & tx_full);
        irq_d    = |(int_stat & int_en_q);
        // Setup/access tracking: toggles through a read, clears between reads
        rd_phase_d = apb_read_en ? ~rd_phase_q : 1'b0;
    end

    // TX FIFO pointer and occupancy next state
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push_ok) tx_wr_ptr_d = tx_wr_ptr_q + TX_PW'(1);
        if (tx_pop)     tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
        case ({tx_push_ok, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // RX FIFO pointer and occupancy next state
    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push_ok) rx_wr_ptr_d = rx_wr_ptr_q + RX_PW'(1);
        if (rx_pop)     rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
        case ({rx_push_ok, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_q      <= 2'b00;
            baud_q      <= BAUD_RST;
            int_en_q    <= 4'h0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            irq_q       <= 1'b0;
            rd_phase_q  <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            baud_q      <= baud_d;
            int_en_q    <= int_en_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ovf_q    <= tx_ovf_d;
            irq_q       <= irq_d;
            rd_phase_q  <= rd_phase_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge pclk) begin
        if (!preset && tx_push_ok) tx_mem_q[tx_wr_ptr_q] <= apb_wdata[7:0];
        if (!preset && rx_push_ok) rx_mem_q[rx_wr_ptr_q] <= rx_data;
    end

endmodule

// File: doc/uart_apb_regfile.md
Name: uart_apb_regfile

Overview:
- Register bank and data FIFOs of the UART IP, directly downstream of the APB-to-internal interface.
- Consumes apb_addr, apb_read_en, apb_write_en and apb_wdata; returns apb_rdata.
- Holds the TX and RX byte FIFOs, control/baud registers and interrupt logic, and feeds the UART transmitter/receiver cores.

Parameters:
ADDR_WD, 12, width of apb_addr
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
BAUD_RST, 16'd868, reset value of BAUD register

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
apb_addr  in  ADDR_WD  byte address; bits [1:0] ignored
apb_read_en  in  1  high for both setup and access phase of a read (psel & ~pwrite)
apb_write_en  in  1  one-cycle write strobe (setup phase)
apb_wdata  in  32  write data
apb_rdata  out  32  read data, combinational from apb_addr
tx_data  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty and CTRL.tx_en
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
rx_data  in  8  received byte
rx_valid  in  1  one-cycle push strobe from receiver, no backpressure
tx_en  out  1  CTRL[0]
rx_en  out  1  CTRL[1]
baud_div  out  16  BAUD[15:0]
irq  out  1  registered interrupt

Behaviour:
- Register map (word offsets):
  - 0x00 DATA: write pushes wdata[7:0] to TX FIFO; read returns {24'b0, RX head} and pops.
  - 0x04 STATUS (RO): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [11:8] tx_count, [19:16] rx_count (zero-extended/truncated to 4 bits).
  - 0x08 CTRL (RW, [1:0]).
  - 0x0C BAUD (RW, [15:0]).
  - 0x10 INT_EN (RW, [3:0]).
  - 0x14 INT_STAT: [0] rx_avail = ~rx_empty (level, RO); [1] tx_empty (level, RO); [2] rx_ovr (sticky, W1C); [3] tx_ovf (sticky, W1C).
- Unmapped reads return 0; unmapped writes are ignored; writes to RO bits are ignored.
- Reset values: CTRL=0, BAUD=BAUD_RST, INT_EN=0, sticky bits=0, both FIFOs empty (pointers and counts 0), irq=0, tx_valid=0.
- Read phase tracking: rd_phase flop, cleared when apb_read_en=0, toggled each cycle apb_read_en=1. Cycles with rd_phase=0 are setup; rd_phase=1 are access. Back-to-back reads give 0,1,0,1.
- RX pop: apb_read_en & rd_phase & addr==DATA & ~rx_empty, on the clock edge ending the access phase. apb_rdata shows the pre-pop head during both phases. Pop from an empty RX FIFO: no pointer change, data 0.
- TX push: apb_write_en & addr==DATA. If TX is full, the byte is dropped and tx_ovf is set.
- TX pop: tx_valid & tx_ready.
- Simultaneous push+pop on a full TX FIFO: still counts as full at the push, so the byte is dropped and tx_ovf is set.
- RX push: rx_valid. If RX is full and no pop occurs in the same cycle, the byte is dropped and rx_ovr is set. Full with simultaneous pop: push accepted, count unchanged, no overrun.
- Simultaneous push+pop (non-full, non-empty): count unchanged; pointers wrap modulo DEPTH.
- Sticky set and W1C clear in the same cycle: set wins.
- rx_en=0: rx_valid is ignored (no push, no overrun). tx_en=0: tx_valid forced 0; FIFO still accepts writes.
- irq <= |(INT_STAT[3:0] & INT_EN[3:0]), one cycle after the cause.
- Reset asserted mid-operation: all state returns to reset values at the next edge and FIFO contents are discarded.

Test Plan:
- Reset, then read 0x04, 0x0C, 0x08 -> 0x0000_000A, 0x0000_0364, 0x0; irq=0, tx_valid=0.
- CTRL=1, tx_ready=0; write DATA 0x41,0x42 -> tx_valid=1, tx_data=0x41, STATUS[11:8]=2. Pulse tx_ready for 2 cycles -> 0x41 then 0x42 consumed, tx_empty=1.
- CTRL=0; write DATA 9 times with TX_DEPTH=8 -> STATUS tx_full=1, INT_STAT[3]=1. Write 0x14 with 0x8 -> bit cleared.
- CTRL=2; push rx 0x11,0x22; two back-to-back reads of DATA -> 0x11 then 0x22, rx_empty=1, exactly two pops.
- CTRL=2, INT_EN=4; push 9 RX bytes -> rx_ovr=1, irq=1 one cycle later. Push a 10th byte while reading DATA (access phase) -> no extra drop, count stays 8.
- Assert preset while TX/RX FIFOs are half full -> next cycle counts=0, irq=0, BAUD=0x364.
